// File: rtl/tk1_spi_target_pkg.sv
// Shared constants for the TK1 SPI target: register map, bit positions, FSM states.
package tk1_spi_target_pkg;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_RX_DATA = 8'h01;
    localparam logic [7:0] ADDR_TX_DATA = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;

    localparam int unsigned ST_RX_AVAIL  = 0;
    localparam int unsigned ST_TX_FULL   = 1;
    localparam int unsigned ST_ACTIVE    = 2;
    localparam int unsigned ST_OVERRUN   = 3;
    localparam int unsigned ST_UNDERRUN  = 4;
    localparam int unsigned ST_COUNT_LSB = 8;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_CLEAR  = 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/tk1_spi_target_fifo.sv
// Byte-wide synchronous RX FIFO; simultaneous push and pop is legal when full.
module tk1_spi_target_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [7:0]                   data_i,
    output logic [7:0]                   data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tk1_spi_target.sv
// SPI mode-0 target: oversampled pins, RX FIFO, one-byte TX holding register, CPU bus regs.
module tk1_spi_target
    import tk1_spi_target_pkg::*;
#(
    parameter int unsigned RX_DEPTH  = 4,
    parameter logic [7:0]  IDLE_BYTE = 8'hff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_ss,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        irq,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    localparam int unsigned CNT_W = $clog2(RX_DEPTH) + 1;

    logic [2:0] ss_q, sck_q;
    logic [1:0] mosi_q;
    logic       ss_fall, ss_rise, sck_rise, sck_fall, mosi_s;

    state_e     state_q, state_d;
    logic       load_c, shift_in_c, shift_out_c, push_c, clear_c;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_full_q, tx_full_d;
    logic       enable_q, enable_d;
    logic       ovr_q, ovr_d, udr_q, udr_d;

    logic             wr_tx, wr_ctrl, rd_rx;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_c, rdata_c;
    logic             unused_wdata;

    assign unused_wdata = ^write_data[31:8];

    // Two-stage synchronisers plus a third stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_q   <= 3'b111;
            sck_q  <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= {ss_q[1:0], spi_ss};
            sck_q  <= {sck_q[1:0], spi_sck};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign ss_fall  =  ss_q[2] & ~ss_q[1];
    assign ss_rise  = ~ss_q[2] &  ss_q[1];
    assign sck_rise = ~sck_q[2] &  sck_q[1];
    assign sck_fall =  sck_q[2] & ~sck_q[1];
    assign mosi_s   =  mosi_q[1];

    assign wr_tx   = cs &  we & (address == ADDR_TX_DATA);
    assign wr_ctrl = cs &  we & (address == ADDR_CTRL);
    assign rd_rx   = cs & ~we & (address == ADDR_RX_DATA);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: frame starts on ss fall, ends on ss rise or disable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable_q && ss_fall)  state_d = S_ACTIVE;
            S_ACTIVE: if (!enable_q || ss_rise) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes for the current cycle.
    always_comb begin
        load_c      = 1'b0;
        shift_in_c  = 1'b0;
        shift_out_c = 1'b0;
        push_c      = 1'b0;
        clear_c     = 1'b0;
        case (state_q)
            S_IDLE: load_c = enable_q & ss_fall;
            S_ACTIVE: begin
                if (!enable_q || ss_rise) begin
                    clear_c = 1'b1;
                end else begin
                    shift_in_c  = sck_rise;
                    push_c      = sck_rise & (bit_cnt_q == 3'd7);
                    shift_out_c = sck_fall & (bit_cnt_q != 3'd0);
                    load_c      = sck_fall & (bit_cnt_q == 3'd0) & byte_done_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath and register-file next state.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        tx_hold_d   = tx_hold_q;
        tx_full_d   = tx_full_q;
        enable_d    = enable_q;
        ovr_d       = ovr_q;
        udr_d       = udr_q;

        if (clear_c) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            tx_shift_d  = 8'hff;
        end
        // Reload sees the holding register as it was before any same-cycle write.
        if (load_c) begin
            tx_shift_d = tx_full_q ? tx_hold_q : IDLE_BYTE;
            tx_full_d  = 1'b0;
        end
        if (shift_out_c) tx_shift_d = {tx_shift_q[6:0], 1'b1};
        if (shift_in_c) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end
        if (push_c) byte_done_d = 1'b1;

        if (wr_tx && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_hold_d = write_data[7:0];
        end
        if (wr_ctrl) begin
            enable_d = write_data[CTRL_ENABLE];
            if (write_data[CTRL_CLEAR]) begin
                ovr_d = 1'b0;
                udr_d = 1'b0;
            end
        end
        // New error events override a same-cycle clear.
        if (push_c && fifo_full && !rd_rx) ovr_d = 1'b1;
        if (load_c && !tx_full_q)          udr_d = 1'b1;
    end

    // Datapath and register-file flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            tx_shift_q  <= 8'hff;
            rx_shift_q  <= 8'h00;
            tx_hold_q   <= 8'h00;
            tx_full_q   <= 1'b0;
            enable_q    <= 1'b0;
            ovr_q       <= 1'b0;
            udr_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            enable_q    <= enable_d;
            ovr_q       <= ovr_d;
            udr_q       <= udr_d;
        end
    end

    tk1_spi_target_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .pop_i   (rd_rx),
        .data_i  ({rx_shift_q[6:0], mosi_s}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // STATUS word assembly.
    always_comb begin
        status_c                            = '0;
        status_c[ST_COUNT_LSB +: CNT_W]     = fifo_count;
        status_c[ST_RX_AVAIL]               = ~fifo_empty;
        status_c[ST_TX_FULL]                = tx_full_q;
        status_c[ST_ACTIVE]                 = (state_q == S_ACTIVE);
        status_c[ST_OVERRUN]                = ovr_q;
        status_c[ST_UNDERRUN]               = udr_q;
    end

    // Combinational read mux; zero when not selected or unmapped.
    always_comb begin
        rdata_c = '0;
        if (cs && !we) begin
            case (address)
                ADDR_STATUS:  rdata_c = status_c;
                ADDR_RX_DATA: rdata_c = fifo_empty ? 32'h0 : 32'(fifo_head);
                ADDR_CTRL:    rdata_c = {31'h0, enable_q};
                default:      rdata_c = '0;
            endcase
        end
    end

    assign read_data = rdata_c;
    assign ready     = cs;
    assign spi_miso  = tx_shift_q[7];
    assign irq       = enable_q & (~fifo_empty | ovr_q | udr_q);

endmodule

// File: tb/tb_tk1_spi_target.sv
// Directed + randomized bench for tk1_spi_target with a frame-level reference model.
module tb_tk1_spi_target;

    localparam int DEPTH = 4;
    localparam int H     = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_ss, spi_sck, spi_mosi, spi_miso, irq;
    logic        cs, we, ready;
    logic [7:0]  address;
    logic [31:0] write_data, read_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_txf, m_en, m_ovr, m_udr, m_act, m_done;
    logic [7:0] m_hold, m_cur, m_sh;
    int         m_bits;

    tk1_spi_target #(.RX_DEPTH(DEPTH), .IDLE_BYTE(8'hff)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_ss     (spi_ss),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .irq        (irq),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        mq.delete();
        m_txf = 0; m_en = 0; m_ovr = 0; m_udr = 0; m_act = 0; m_done = 0;
        m_hold = 0; m_cur = 8'hff; m_sh = 0; m_bits = 0;
    endtask

    function automatic logic [7:0] m_take();
        if (m_txf) begin
            m_txf = 0;
            return m_hold;
        end
        m_udr = 1;
        return 8'hff;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = 32'(mq.size()) << 8;
        s[0] = (mq.size() != 0);
        s[1] = m_txf;
        s[2] = m_act;
        s[3] = m_ovr;
        s[4] = m_udr;
        return s;
    endfunction

    function automatic logic m_irq();
        return m_en & ((mq.size() != 0) | m_ovr | m_udr);
    endfunction

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1; we = 1; address = a; write_data = d;
        @(negedge clk);
        cs = 0; we = 0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1; we = 0; address = a;
        #1 d = read_data;
        @(negedge clk);
        cs = 0;
    endtask

    task automatic wr_tx(input logic [7:0] d);
        bus_wr(8'h02, 32'(d));
        if (!m_txf) begin
            m_txf = 1;
            m_hold = d;
        end
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        bus_wr(8'h03, d);
        m_en = d[0];
        if (d[1]) begin
            m_ovr = 0;
            m_udr = 0;
        end
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_rd(8'h00, d);
        chk(tag, d, m_status());
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] d, e;
        e = (mq.size() != 0) ? 32'(mq.pop_front()) : 32'h0;
        bus_rd(8'h01, d);
        chk(tag, d, e);
    endtask

    task automatic ss_low();
        spi_ss = 0;
        if (m_en) begin
            m_act = 1; m_bits = 0; m_done = 0;
            m_cur = m_take();
        end
        clks(8);
    endtask

    task automatic ss_high();
        clks(H);
        spi_ss = 1;
        m_act = 0;
        clks(8);
        spi_sck = 0;
        clks(4);
    endtask

    task automatic rise_bit(input logic b, output logic s);
        spi_mosi = b;
        clks(H);
        s = spi_miso;
        spi_sck = 1;
        if (m_act) begin
            m_sh = {m_sh[6:0], b};
            m_bits++;
            if (m_bits == 8) begin
                if (mq.size() < DEPTH) mq.push_back(m_sh);
                else m_ovr = 1;
                m_bits = 0;
                m_done = 1;
            end
        end
        clks(H);
    endtask

    task automatic fall_edge();
        spi_sck = 0;
        if (m_act && m_bits == 0 && m_done) m_cur = m_take();
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, input bit last_fall, input string tag);
        logic [7:0] got, exp;
        logic       s;
        got = '0;
        exp = m_act ? m_cur : 8'hff;
        for (int i = 0; i < nbits; i++) begin
            rise_bit(tx[7-i], s);
            got = {got[6:0], s};
            if (i < nbits - 1 || last_fall) fall_edge();
        end
        if (nbits == 8) chk(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        logic [31:0] d;
        m_reset();
        reset_n = 0; spi_ss = 1; spi_sck = 0; spi_mosi = 0;
        cs = 0; we = 0; address = 0; write_data = 0;
        clks(3);
        chk("rst_miso", 32'(spi_miso), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        reset_n = 1;
        clks(2);
        check_status("rst_status");

        // Loaded TX byte exchanged for a received byte
        wr_ctrl(32'h1);
        bus_rd(8'h03, d);
        chk("ctrl_read", d, 32'h1);
        wr_tx(8'hA5);
        ss_low();
        xfer(8'h3C, 8, 0, "t1_miso");
        check_status("t1_status_active");
        check_rx("t1_rx");
        ss_high();
        check_status("t1_status_idle");

        // No TX load: idle byte, underrun, irq behaviour
        ss_low();
        xfer(8'h11, 8, 0, "t2_miso");
        ss_high();
        chk("t2_irq_set", 32'(irq), 32'(m_irq()));
        check_status("t2_status");
        wr_ctrl(32'h3);
        clks(1);
        chk("t2_irq_rx", 32'(irq), 32'(m_irq()));
        check_rx("t2_rx");
        clks(1);
        chk("t2_irq_clr", 32'(irq), 32'(m_irq()));

        // FIFO overflow: five bytes into a four-deep FIFO
        ss_low();
        for (int b = 1; b <= 5; b++) xfer(8'(b), 8, b < 5, "t3_miso");
        ss_high();
        check_status("t3_status");
        for (int k = 0; k < 5; k++) check_rx("t3_rx");
        wr_ctrl(32'h3);

        // Aborted partial byte, then a full frame
        wr_tx(8'hC3);
        ss_low();
        xfer(8'h80, 5, 1, "t4_partial");
        ss_high();
        ss_low();
        xfer(8'h7E, 8, 0, "t4_miso");
        ss_high();
        check_status("t4_status");
        check_rx("t4_rx");
        check_rx("t4_rx_empty");
        wr_ctrl(32'h3);

        // Two-byte frame with reload between bytes; write while full ignored
        wr_tx(8'h12);
        wr_tx(8'h99);
        check_status("t5_status_full");
        ss_low();
        xfer(8'hA1, 8, 0, "t5_miso0");
        wr_tx(8'h34);
        fall_edge();
        xfer(8'hB2, 8, 0, "t5_miso1");
        ss_high();
        check_rx("t5_rx0");
        check_rx("t5_rx1");
        check_status("t5_status");

        // Randomized frames
        for (int f = 0; f < 5; f++) begin
            int n;
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
            ss_low();
            for (int k = 0; k < n; k++) begin
                xfer(8'($urandom), 8, 0, "rnd_miso");
                if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
                if (k < n - 1) fall_edge();
            end
            ss_high();
            check_status("rnd_status");
            for (int k = 0; k < n; k++) check_rx("rnd_rx");
            chk("rnd_irq", 32'(irq), 32'(m_irq()));
            wr_ctrl(32'h3);
        end

        // Reset mid-bit
        wr_tx(8'h55);
        ss_low();
        begin
            logic s;
            rise_bit(1'b0, s);
        end
        reset_n = 0;
        clks(1);
        chk("rst2_miso", 32'(spi_miso), 32'h1);
        chk("rst2_irq", 32'(irq), 32'h0);
        spi_ss = 1; spi_sck = 0;
        m_reset();
        clks(2);
        reset_n = 1;
        clks(4);
        check_status("rst2_status");
        ss_low();
        xfer(8'h5A, 8, 1, "rst2_disabled_miso");
        ss_high();
        check_status("rst2_ignored");
        wr_ctrl(32'h1);
        ss_low();
        xfer(8'h6B, 8, 0, "rst2_enabled_miso");
        ss_high();
        check_rx("rst2_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
